ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of alu_result, store_data, pc, epc.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream EX beat present.
REQ-005 SHALL have port in_ready, output, 1: stage can accept a beat.
REQ-006 SHALL have ports alu_result, input, DATA_WIDTH, and alu_overflow, input, 1: ALU result and overflow.
REQ-007 SHALL have port ovf_check, input, 1: beat is a trapping signed add or sub.
REQ-008 SHALL have ports rd, input, 5; reg_write, mem_read, mem_write, input, 1 each: destination register and control.
REQ-009 SHALL have ports store_data, input, DATA_WIDTH, and pc, input, DATA_WIDTH: store operand and instruction PC.
REQ-010 SHALL have port flush, input, 1: discard all held beats.
REQ-011 SHALL have ports out_valid, output, 1, and out_ready, input, 1: MEM-side handshake.
REQ-012 SHALL have ports out_result, out_store_data, output, DATA_WIDTH; out_rd, output, 5; out_reg_write, out_mem_read, out_mem_write, output, 1 each: head-entry fields.
REQ-013 SHALL have ports exc_valid, output, 1; epc, output, DATA_WIDTH; exc_ack, input, 1: overflow exception report.

Function
REQ-014 SHALL implement a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-015 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, registered with no combinational path from out_ready.
REQ-016 SHALL accept on in_valid & in_ready and deliver on out_valid & out_ready.
REQ-017 SHALL drive out_valid = 1 in ONE and FULL; all out_* fields come from the head entry register.
REQ-018 SHALL present a beat accepted at edge N on the outputs from cycle N+1: latency of 1.
REQ-019 SHALL, in ONE with simultaneous accept and deliver, stay in ONE with the new beat as head.
REQ-020 SHALL, in FULL with deliver, move to ONE with the second entry promoted to head in order.
REQ-021 SHALL hold out_* fields stable while out_valid & !out_ready.
REQ-022 SHALL, on flush, go to EMPTY at the next edge and drop any same-cycle incoming beat; a same-cycle deliver counts as complete.
REQ-023 SHALL give flush priority over accept; rst priority over flush.
REQ-024 SHALL treat out_* fields as don't-care when out_valid = 0, except that control bits are driven 0.

Reset
REQ-025 SHALL, on rst, enter EMPTY and drive in_ready = 1, out_valid = 0, all out_* fields = 0, exc_valid = 0, epc = 0.
REQ-026 SHALL, on rst asserted mid-transfer, discard all buffered beats with no partial delivery.

Configuration
REQ-027 SHALL gate overflow trapping with macro EX_MEM_OVF_TRAP_EN.
REQ-028 SHALL, with EX_MEM_OVF_TRAP_EN defined, handle a beat accepted with ovf_check & alu_overflow as follows: force stored reg_write, mem_read, mem_write to 0; set exc_valid at the next edge; load epc = pc.
REQ-029 SHALL, with EX_MEM_OVF_TRAP_EN defined, keep exc_valid set until exc_ack.
REQ-030 SHALL, with EX_MEM_OVF_TRAP_EN defined, not overwrite epc while exc_valid = 1 (first trap wins), except when exc_ack and a new trapping accept coincide: exc_valid stays 1 and epc takes the new pc.
REQ-031 SHALL, with EX_MEM_OVF_TRAP_EN defined, leave exc_valid and epc unchanged on flush.
REQ-032 SHALL, without EX_MEM_OVF_TRAP_EN, ignore alu_overflow, ovf_check and exc_ack, and tie exc_valid and epc to 0.

Verification
REQ-033 SHALL cover: rst, then one beat alu_result=0x0000_0010, rd=5, reg_write=1, out_ready=1 -> out_valid=1 one cycle later with out_result=0x10, out_rd=5; then out_valid=0.
REQ-034 SHALL cover: out_ready=0, three consecutive beats A, B, C -> in_ready=0 after B, C stalls; release out_ready -> A, B, C delivered in order, none lost.
REQ-035 SHALL cover: FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the incoming beat is never delivered.
REQ-036 SHALL cover, with EX_MEM_OVF_TRAP_EN: beat pc=0x0040_0008, ovf_check=1, alu_overflow=1, reg_write=1 -> out_reg_write=0, exc_valid=1, epc=0x0040_0008; a second trap at pc=0x0040_000C leaves epc unchanged; exc_ack clears exc_valid.
REQ-037 SHALL cover, without EX_MEM_OVF_TRAP_EN: the same overflowing beat -> out_reg_write=1, exc_valid=0 throughout.
REQ-038 SHALL cover: rst asserted in FULL -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: a 2-entry in-order skid buffer between EX and MEM with an optional
// overflow trap, which is compiled in only when EX_MEM_OVF_TRAP_EN is defined (default: trap logic removed).
module ex_mem_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    input  logic                  ovf_check,
    input  logic [4:0]            rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [4:0]            out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  exc_valid,
    output logic [DATA_WIDTH-1:0] epc,
    input  logic                  exc_ack
);
    // state | meaning
    // EMPTY | no beat held, out_valid = 0
    // ONE   | head holds the only beat
    // FULL  | head and tail both hold beats, in_ready = 0
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [4:0]            rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } entry_t;

    state_t state;
    entry_t head, tail, incoming;
    logic   trap, accept, deliver;

    always_comb begin
`ifdef EX_MEM_OVF_TRAP_EN
        trap = ovf_check & alu_overflow;
`else
        trap = 1'b0;
`endif
        incoming.result     = alu_result;
        incoming.store_data = store_data;
        incoming.rd         = rd;
        // A trapping beat must not retire any architectural side effect
        incoming.reg_write  = reg_write & ~trap;
        incoming.mem_read   = mem_read  & ~trap;
        incoming.mem_write  = mem_write & ~trap;
    end

    assign accept  = in_valid & in_ready & ~flush;
    assign deliver = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head      <= '0;
            tail      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state          <= EMPTY;
            head.reg_write <= 1'b0;
            head.mem_read  <= 1'b0;
            head.mem_write <= 1'b0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head      <= incoming;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    case ({accept, deliver})
                        2'b11: head <= incoming;
                        2'b10: begin
                            tail     <= incoming;
                            state    <= FULL;
                            in_ready <= 1'b0;
                        end
                        2'b01: begin
                            state          <= EMPTY;
                            out_valid      <= 1'b0;
                            head.reg_write <= 1'b0;
                            head.mem_read  <= 1'b0;
                            head.mem_write <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (deliver) begin
                        head     <= tail;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_result     = head.result;
    assign out_store_data = head.store_data;
    assign out_rd         = head.rd;
    assign out_reg_write  = head.reg_write;
    assign out_mem_read   = head.mem_read;
    assign out_mem_write  = head.mem_write;

`ifdef EX_MEM_OVF_TRAP_EN
    // First trap wins; an ack coinciding with a new trap hands over to the new one
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_valid <= 1'b0;
            epc       <= '0;
        end else if (accept && trap) begin
            exc_valid <= 1'b1;
            if (!exc_valid || exc_ack) epc <= pc;
        end else if (exc_ack) begin
            exc_valid <= 1'b0;
        end
    end
`else
    logic unused_trap_inputs;
    assign unused_trap_inputs = ovf_check ^ alu_overflow ^ exc_ack ^ (^pc);
    assign exc_valid = 1'b0;
    assign epc       = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic against a queue model.
// Build with or without EX_MEM_OVF_TRAP_EN to match the DUT.
module tb_ex_mem_stage;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, alu_overflow, ovf_check;
    logic [W-1:0] alu_result, store_data, pc;
    logic [4:0]   rd;
    logic         reg_write, mem_read, mem_write, flush;
    logic         out_valid, out_ready;
    logic [W-1:0] out_result, out_store_data, epc;
    logic [4:0]   out_rd;
    logic         out_reg_write, out_mem_read, out_mem_write, exc_valid, exc_ack;

    ex_mem_stage #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .ovf_check(ovf_check),
        .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .store_data(store_data), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .exc_valid(exc_valid), .epc(epc), .exc_ack(exc_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] result;
        logic [W-1:0] sdata;
        logic [4:0]   rd;
        logic         rw, mr, mw;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] delivered[$];
    logic         m_exc;
    logic [W-1:0] m_epc;
    logic         last_acc;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_exc = 1'b0;
        m_epc = '0;
    endtask

    // Compare outputs against the model, then advance the model and the DUT by one clock.
    task automatic step();
        bit    acc, del, trap;
        beat_t b;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("exc_valid", exc_valid, m_exc);
        chk("epc", epc, m_epc);
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].result);
            chk("out_store_data", out_store_data, q[0].sdata);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_ctrl", {out_reg_write, out_mem_read, out_mem_write}, {q[0].rw, q[0].mr, q[0].mw});
        end else begin
            chk("idle_ctrl", {out_reg_write, out_mem_read, out_mem_write}, 3'b000);
        end

        last_acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            del = (q.size() > 0) && out_ready;
            acc = in_valid && (q.size() < 2) && !flush;
`ifdef EX_MEM_OVF_TRAP_EN
            trap = ovf_check && alu_overflow;
`else
            trap = 1'b0;
`endif
            if (del) delivered.push_back(q[0].result);
            if (flush) q.delete();
            else if (del) void'(q.pop_front());
            if (acc) begin
                b.result = alu_result;
                b.sdata  = store_data;
                b.rd     = rd;
                b.rw     = reg_write && !trap;
                b.mr     = mem_read && !trap;
                b.mw     = mem_write && !trap;
                q.push_back(b);
                last_acc = 1'b1;
            end
`ifdef EX_MEM_OVF_TRAP_EN
            if (acc && trap) begin
                if (!m_exc || exc_ack) m_epc = pc;
                m_exc = 1'b1;
            end else if (exc_ack) begin
                m_exc = 1'b0;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [W-1:0] res, input logic [4:0] r, input logic rw, input logic [W-1:0] p);
        in_valid     = 1'b1;
        alu_result   = res;
        rd           = r;
        reg_write    = rw;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        store_data   = res ^ 32'hA5A5_0000;
        pc           = p;
        ovf_check    = 1'b0;
        alu_overflow = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_fields"}, {out_result, out_rd, out_reg_write, out_mem_read, out_mem_write}, '0);
        chk({tag, "_store"}, out_store_data, '0);
        chk({tag, "_exc"}, {exc_valid, epc}, '0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_result = '0; alu_overflow = 1'b0; ovf_check = 1'b0;
        rd = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; store_data = '0;
        pc = '0; flush = 1'b0; out_ready = 1'b0; exc_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single beat, latency 1
        out_ready = 1'b1;
        set_beat(32'h0000_0010, 5'd5, 1'b1, 32'h0000_1000);
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1'b1);
        chk("single_result", out_result, 32'h10);
        chk("single_rd", out_rd, 5'd5);
        step();
        chk("single_done", out_valid, 1'b0);

        // Backpressure: A, B fill the buffer, C stalls until MEM drains
        delivered.delete();
        out_ready = 1'b0;
        set_beat(32'hAAAA_0001, 5'd1, 1'b1, 32'h0000_2000); step();
        set_beat(32'hBBBB_0002, 5'd2, 1'b1, 32'h0000_2004); step();
        chk("bp_in_ready_full", in_ready, 1'b0);
        set_beat(32'hCCCC_0003, 5'd3, 1'b0, 32'h0000_2008);
        step(); step();
        chk("bp_c_stalled", last_acc, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && !last_acc; i++) step();
        chk("bp_c_accepted", last_acc, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) step();
        chk("bp_drained", q.size(), 0);
        chk("bp_count", delivered.size(), 3);
        if (delivered.size() == 3) begin
            chk("bp_order_a", delivered[0], 32'hAAAA_0001);
            chk("bp_order_b", delivered[1], 32'hBBBB_0002);
            chk("bp_order_c", delivered[2], 32'hCCCC_0003);
        end
        step();

        // Flush from FULL drops the same-cycle incoming beat
        out_ready = 1'b0;
        set_beat(32'h1111_0001, 5'd7, 1'b1, 32'h0000_3000); step();
        set_beat(32'h2222_0002, 5'd8, 1'b1, 32'h0000_3004); step();
        set_beat(32'hDEAD_BEEF, 5'd9, 1'b1, 32'h0000_3008);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        delivered.delete();
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_nothing_delivered", delivered.size(), 0);

        // Overflowing beats
        set_beat(32'h7FFF_FFFF, 5'd10, 1'b1, 32'h0040_0008);
        ovf_check = 1'b1; alu_overflow = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef EX_MEM_OVF_TRAP_EN
        chk("trap_rw", out_reg_write, 1'b0);
        chk("trap_exc", exc_valid, 1'b1);
        chk("trap_epc", epc, 32'h0040_0008);
`else
        chk("notrap_rw", out_reg_write, 1'b1);
        chk("notrap_exc", exc_valid, 1'b0);
`endif
        set_beat(32'h8000_0000, 5'd11, 1'b1, 32'h0040_000C);
        ovf_check = 1'b1; alu_overflow = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef EX_MEM_OVF_TRAP_EN
        chk("trap2_epc_kept", epc, 32'h0040_0008);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        chk("trap_ack_clear", exc_valid, 1'b0);
`else
        chk("notrap2_exc", {exc_valid, epc}, '0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        chk("notrap_ack_exc", exc_valid, 1'b0);
`endif
        ovf_check = 1'b0; alu_overflow = 1'b0;
        repeat (2) step();

        // Reset while FULL
        out_ready = 1'b0;
        set_beat(32'h3333_0001, 5'd12, 1'b1, 32'h0000_4000); step();
        set_beat(32'h4444_0002, 5'd13, 1'b1, 32'h0000_4004); step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_full");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            rst          = ($urandom_range(0, 79) == 0);
            alu_result   = $urandom;
            store_data   = $urandom;
            pc           = $urandom;
            rd           = 5'($urandom);
            reg_write    = 1'($urandom);
            mem_read     = 1'($urandom);
            mem_write    = 1'($urandom);
            ovf_check    = ($urandom_range(0, 3) == 0);
            alu_overflow = 1'($urandom);
            exc_ack      = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
